// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Converts a signed-magnitude binary value to per-digit decoder codes using a
// sequential shift-add-3 conversion. It then time-multiplexes those codes across
// DIGITS common-anode digits that share a single 7-segment decoder.
// Decoder codes: 0-9 digit, 10 dash, 11 blank.

module display_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  value,
    input  logic              neg,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic [3:0]        digit_code,
    output logic [DIGITS-1:0] anode
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FORMAT = 2'd2
    } state_t;

    // 10^n as a 64-bit constant; used only for the overflow limits
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Largest magnitude that fits: all digits for positive values, one digit
    // fewer for negative values because the leading digit holds the dash.
    localparam logic [63:0] LIM_POS = pow10(DIGITS) - 64'd1;
    localparam logic [63:0] LIM_NEG = pow10(DIGITS - 1) - 64'd1;

    // One double-dabble step: correct every nibble >= 5, then shift {bcd,bin} left
    function automatic logic [BCD_W+WIDTH-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                                       input logic [WIDTH-1:0] bin);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end else begin
                adj[i*4 +: 4] = adj[i*4 +: 4];
            end
        end
        return {adj, bin} << 1'b1;
    endfunction

    // Turn the finished BCD into displayed codes: dashes on overflow, blanking
    // above the leading digit, and a sign dash just left of it for nonzero negatives.
    function automatic logic [BCD_W-1:0] format_digits(input logic [BCD_W-1:0] bcd,
                                                       input logic             is_neg,
                                                       input logic             is_ovf);
        logic [BCD_W-1:0] r;
        int               m;
        logic             nz;
        r  = '0;
        m  = 0;
        nz = |bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) begin
                m = i;
            end else begin
                m = m;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (is_ovf) begin
                r[i*4 +: 4] = CODE_DASH;
            end else if (i <= m) begin
                r[i*4 +: 4] = bcd[i*4 +: 4];
            end else if (is_neg && nz && (i == m + 1)) begin
                r[i*4 +: 4] = CODE_DASH;
            end else begin
                r[i*4 +: 4] = CODE_BLANK;
            end
        end
        return r;
    endfunction

    state_t             state_r;
    logic [WIDTH-1:0]   bin_r;
    logic [BCD_W-1:0]   bcd_r;
    logic               neg_r;
    logic               ovf_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [BCD_W-1:0]   shadow_r;
    logic [REF_W-1:0]   ref_cnt_r;
    logic [SEL_W-1:0]   sel_r;
    logic [DIGITS-1:0]  anode_r;
    logic [3:0]         digit_code_r;

    logic [BCD_W-1:0]   shadow_nxt_s;
    logic [SEL_W-1:0]   sel_nxt_s;
    logic               ref_tc_s;
    logic               ovf_s;
    logic [63:0]        value_ext_s;

    // Next shadow contents, next scan position and the capture-time overflow decision
    always_comb begin
        shadow_nxt_s = shadow_r;
        sel_nxt_s    = sel_r;
        value_ext_s  = 64'(value);
        if (state_r == ST_FORMAT) begin
            shadow_nxt_s = format_digits(bcd_r, neg_r, ovf_r);
        end else begin
            shadow_nxt_s = shadow_r;
        end
        ref_tc_s = (ref_cnt_r == REF_W'(REFRESH_DIV - 1));
        if (ref_tc_s) begin
            if (sel_r == SEL_W'(DIGITS - 1)) begin
                sel_nxt_s = '0;
            end else begin
                sel_nxt_s = sel_r + SEL_W'(1);
            end
        end else begin
            sel_nxt_s = sel_r;
        end
        if (neg) begin
            ovf_s = (value_ext_s > LIM_NEG);
        end else begin
            ovf_s = (value_ext_s > LIM_POS);
        end
    end

    // Conversion FSM: capture, WIDTH shift-add-3 steps, then one atomic shadow update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            bin_r    <= '0;
            bcd_r    <= '0;
            neg_r    <= 1'b0;
            ovf_r    <= 1'b0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            shadow_r <= {DIGITS{CODE_BLANK}};
        end else begin
            shadow_r <= shadow_nxt_s;
            done_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        bin_r   <= value;
                        bcd_r   <= '0;
                        neg_r   <= neg;
                        ovf_r   <= ovf_s;
                        cnt_r   <= CNT_W'(WIDTH);
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    {bcd_r, bin_r} <= dd_step(bcd_r, bin_r);
                    cnt_r          <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= ST_FORMAT;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_FORMAT: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running refresh scan; digit_code follows the next shadow so new digits show with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_r    <= '0;
            sel_r        <= '0;
            anode_r      <= ~(DIGITS'(1));
            digit_code_r <= CODE_BLANK;
        end else begin
            if (ref_tc_s) begin
                ref_cnt_r <= '0;
            end else begin
                ref_cnt_r <= ref_cnt_r + REF_W'(1);
            end
            sel_r        <= sel_nxt_s;
            anode_r      <= ~(DIGITS'(1) << sel_nxt_s);
            digit_code_r <= shadow_nxt_s[int'(sel_nxt_s)*4 +: 4];
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign digit_code = digit_code_r;
    assign anode      = anode_r;

endmodule
